pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32I pipeline. It owns the per-stage valid bits and drives the load enables of the PC and of the four pipeline registers: fetch/decode, decode/execute, execute/memory and memory/writeback. It resolves D-cache stalls, I-cache stalls, load-use hazards and branch mispredicts with a fixed priority. It also discards a wrong-path I-cache response that is still in flight when a mispredict occurs.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 12 +
 rtl/pipe_hazard_ctrl_perf_cnt.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control types: hazard FSM state and PC reset vector.
// Imported by the hazard controller and the pipeline registers.
package cpuIO;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pipe_state_t;

    localparam logic [31:0] PIPE_PC_RESET = 32'h4000_0000;

endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// Saturating performance counter; holds at all-ones instead of wrapping.
// Ports: clk, rst (async high), inc_i (count enable), cnt_o (value).
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stage valids, PC and
// pipeline-register load enables, wrong-path I-fetch discard (FLUSH state).
// Inputs : clk, rst, imem_resp, dmem_resp, mem_access, load_use, br_mispredict
// Outputs: imem_read, pc_ld, fd/de/em/mw_ld, fd/de/em/mw_valid, flushing,
//          stall_i_cnt, stall_d_cnt, flush_cnt (live only with PIPE_CTRL_PERF_EN,
//          otherwise tied to 0).
module pipe_hazard_ctrl
    import cpuIO::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_resp,
    input  logic             dmem_resp,
    input  logic             mem_access,
    input  logic             load_use,
    input  logic             br_mispredict,
    output logic             imem_read,
    output logic             pc_ld,
    output logic             fd_ld,
    output logic             de_ld,
    output logic             em_ld,
    output logic             mw_ld,
    output logic             fd_valid,
    output logic             de_valid,
    output logic             em_valid,
    output logic             mw_valid,
    output logic             flushing,
    output logic [CNT_W-1:0] stall_i_cnt,
    output logic [CNT_W-1:0] stall_d_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pipe_state_t state_q, state_d;
    // {fd, de, em, mw}
    logic [3:0]  valid_q, valid_d;
    logic        mem_stall;
    logic        fetch_ok;
    logic        inc_i_stall;
    logic        inc_flush;

    assign mem_stall = valid_q[1] & mem_access & ~dmem_resp;
    assign fetch_ok  = imem_resp & (state_q == RUN);

    always_comb begin
        pc_ld       = 1'b0;
        fd_ld       = 1'b0;
        de_ld       = 1'b0;
        em_ld       = 1'b0;
        mw_ld       = 1'b0;
        valid_d     = valid_q;
        state_d     = state_q;
        inc_i_stall = 1'b0;
        inc_flush   = 1'b0;

        if (mem_stall) begin
            // Everything freezes, including the FSM.
            valid_d = valid_q;
        end else if (br_mispredict && valid_q[2]) begin
            pc_ld     = 1'b1;
            fd_ld     = 1'b1;
            de_ld     = 1'b1;
            em_ld     = 1'b1;
            mw_ld     = 1'b1;
            valid_d   = {2'b00, 1'b1, valid_q[1]};
            inc_flush = 1'b1;
            // A fetch still outstanding belongs to the wrong path.
            if ((state_q == FLUSH) || !imem_resp) begin
                state_d = FLUSH;
            end else begin
                state_d = RUN;
            end
        end else if (load_use && valid_q[3] && valid_q[2]) begin
            de_ld   = 1'b1;
            em_ld   = 1'b1;
            mw_ld   = 1'b1;
            valid_d = {valid_q[3], 1'b0, valid_q[2], valid_q[1]};
            if ((state_q == FLUSH) && imem_resp) begin
                state_d = RUN;
            end
        end else if (!fetch_ok) begin
            fd_ld       = 1'b1;
            de_ld       = 1'b1;
            em_ld       = 1'b1;
            mw_ld       = 1'b1;
            valid_d     = {1'b0, valid_q[3:1]};
            inc_i_stall = (state_q == RUN);
            // The response arriving in FLUSH is the wrong-path one: drop it.
            if ((state_q == FLUSH) && imem_resp) begin
                state_d = RUN;
            end
        end else begin
            pc_ld   = 1'b1;
            fd_ld   = 1'b1;
            de_ld   = 1'b1;
            em_ld   = 1'b1;
            mw_ld   = 1'b1;
            valid_d = {1'b1, valid_q[3:1]};
        end

        if (rst) begin
            pc_ld = 1'b0;
            fd_ld = 1'b0;
            de_ld = 1'b0;
            em_ld = 1'b0;
            mw_ld = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            valid_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    assign imem_read = ~rst;
    assign fd_valid  = valid_q[3];
    assign de_valid  = valid_q[2];
    assign em_valid  = valid_q[1];
    assign mw_valid  = valid_q[0];
    assign flushing  = (state_q == FLUSH);

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall_i (
        .clk   (clk),
        .rst   (rst),
        .inc_i (inc_i_stall),
        .cnt_o (stall_i_cnt)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall_d (
        .clk   (clk),
        .rst   (rst),
        .inc_i (mem_stall),
        .cnt_o (stall_d_cnt)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst   (rst),
        .inc_i (inc_flush),
        .cnt_o (flush_cnt)
    );
`else
    logic unused_cnt;
    assign unused_cnt  = inc_i_stall ^ inc_flush;
    assign stall_i_cnt = '0;
    assign stall_d_cnt = '0;
    assign flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a scoreboard of expected
// next-cycle valids/flushing; combinational enables checked in-cycle.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             imem_resp = 1'b0;
    logic             dmem_resp = 1'b0;
    logic             mem_access = 1'b0;
    logic             load_use = 1'b0;
    logic             br_mispredict = 1'b0;
    logic             imem_read;
    logic             pc_ld, fd_ld, de_ld, em_ld, mw_ld;
    logic             fd_valid, de_valid, em_valid, mw_valid;
    logic             flushing;
    logic [CNT_W-1:0] stall_i_cnt, stall_d_cnt, flush_cnt;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        string    tag;
        logic [3:0] v;
        logic     fl;
    } exp_t;

    exp_t sb[$];

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_resp     (imem_resp),
        .dmem_resp     (dmem_resp),
        .mem_access    (mem_access),
        .load_use      (load_use),
        .br_mispredict (br_mispredict),
        .imem_read     (imem_read),
        .pc_ld         (pc_ld),
        .fd_ld         (fd_ld),
        .de_ld         (de_ld),
        .em_ld         (em_ld),
        .mw_ld         (mw_ld),
        .fd_valid      (fd_valid),
        .de_valid      (de_valid),
        .em_valid      (em_valid),
        .mw_valid      (mw_valid),
        .flushing      (flushing),
        .stall_i_cnt   (stall_i_cnt),
        .stall_d_cnt   (stall_d_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] obs,
                           input int n);
        logic [CNT_W-1:0] e;
        e = PERF ? CNT_W'(n) : '0;
        chk(tag, 8'(obs), 8'(e));
    endtask

    // in = {imem_resp, dmem_resp, mem_access, load_use, br_mispredict}
    // ld = {pc, fd, de, em, mw}; nv = next {fd, de, em, mw}
    task automatic step(input string tag, input logic [4:0] in,
                        input logic [4:0] ld, input logic [3:0] nv,
                        input logic nfl);
        exp_t e;
        {imem_resp, dmem_resp, mem_access, load_use, br_mispredict} = in;
        #1;
        chk({tag, ".ld"}, {3'b0, pc_ld, fd_ld, de_ld, em_ld, mw_ld}, {3'b0, ld});
        e.tag = tag;
        e.v   = nv;
        e.fl  = nfl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".v"}, {4'b0, fd_valid, de_valid, em_valid, mw_valid},
            {4'b0, e.v});
        chk({e.tag, ".fl"}, {7'b0, flushing}, {7'b0, e.fl});
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        imem_resp = 1'b1;
        #1;
        chk("rst.ld", {3'b0, pc_ld, fd_ld, de_ld, em_ld, mw_ld}, 8'h00);
        chk("rst.imem_read", {7'b0, imem_read}, 8'h00);
        chk("rst.v", {4'b0, fd_valid, de_valid, em_valid, mw_valid}, 8'h00);
        chk("rst.fl", {7'b0, flushing}, 8'h00);
        chk_cnt("rst.cnt_d", stall_d_cnt, 0);
        rst = 1'b0;
        #1;
        chk("run.imem_read", {7'b0, imem_read}, 8'h01);

        // fill
        step("fill1", 5'b10000, 5'b11111, 4'b1000, 1'b0);
        step("fill2", 5'b10000, 5'b11111, 4'b1100, 1'b0);
        step("fill3", 5'b10000, 5'b11111, 4'b1110, 1'b0);
        step("fill4", 5'b10000, 5'b11111, 4'b1111, 1'b0);
        step("fill5", 5'b10000, 5'b11111, 4'b1111, 1'b0);

        // D-cache stall x5, then release
        for (int i = 0; i < 5; i++)
            step("dstall", 5'b10100, 5'b00000, 4'b1111, 1'b0);
        chk_cnt("dstall.cnt_d", stall_d_cnt, 5);
        step("drel", 5'b11100, 5'b11111, 4'b1111, 1'b0);

        // load-use bubble
        step("lu", 5'b10010, 5'b00111, 4'b1011, 1'b0);
        step("lu.a1", 5'b10000, 5'b11111, 4'b1101, 1'b0);
        step("lu.a2", 5'b10000, 5'b11111, 4'b1110, 1'b0);
        step("lu.a3", 5'b10000, 5'b11111, 4'b1111, 1'b0);

        // mispredict with fetch pending
        step("mp", 5'b00001, 5'b11111, 4'b0011, 1'b1);
        step("mp.wait", 5'b00000, 5'b01111, 4'b0001, 1'b1);
        step("mp.drop", 5'b10000, 5'b01111, 4'b0000, 1'b0);
        chk_cnt("mp.cnt_f", flush_cnt, 1);
        chk_cnt("mp.cnt_i", stall_i_cnt, 0);
        step("mp.r1", 5'b10000, 5'b11111, 4'b1000, 1'b0);
        step("mp.r2", 5'b10000, 5'b11111, 4'b1100, 1'b0);
        step("mp.r3", 5'b10000, 5'b11111, 4'b1110, 1'b0);
        step("mp.r4", 5'b10000, 5'b11111, 4'b1111, 1'b0);

        // I-cache stall in RUN
        step("istall", 5'b00000, 5'b01111, 4'b0111, 1'b0);
        chk_cnt("istall.cnt_i", stall_i_cnt, 1);
        step("is.r1", 5'b10000, 5'b11111, 4'b1011, 1'b0);
        step("is.r2", 5'b10000, 5'b11111, 4'b1101, 1'b0);
        step("is.r3", 5'b10000, 5'b11111, 4'b1110, 1'b0);
        step("is.r4", 5'b10000, 5'b11111, 4'b1111, 1'b0);

        // mispredict during D-stall: flush waits for dmem_resp
        for (int i = 0; i < 3; i++)
            step("dsmp", 5'b10101, 5'b00000, 4'b1111, 1'b0);
        chk_cnt("dsmp.cnt_f", flush_cnt, 1);
        step("dsmp.go", 5'b11101, 5'b11111, 4'b0011, 1'b0);
        chk_cnt("dsmp.cnt_f2", flush_cnt, 2);
        chk_cnt("dsmp.cnt_d", stall_d_cnt, 8);
        step("dsmp.a1", 5'b10000, 5'b11111, 4'b1001, 1'b0);

        // mispredict beats load-use
        step("mplu.pre", 5'b10000, 5'b11111, 4'b1100, 1'b0);
        step("mplu", 5'b10011, 5'b11111, 4'b0010, 1'b0);
        chk_cnt("mplu.cnt_f", flush_cnt, 3);
        step("mplu.a1", 5'b10000, 5'b11111, 4'b1001, 1'b0);
        step("mplu.a2", 5'b10000, 5'b11111, 4'b1100, 1'b0);
        step("mplu.a3", 5'b10000, 5'b11111, 4'b1110, 1'b0);

        // counter saturation at 15
        for (int i = 0; i < 10; i++)
            step("sat", 5'b10100, 5'b00000, 4'b1110, 1'b0);
        chk_cnt("sat.cnt_d", stall_d_cnt, 15);

        // reset mid-FLUSH
        step("rf.mp", 5'b00001, 5'b11111, 4'b0011, 1'b1);
        br_mispredict = 1'b0;
        rst = 1'b1;
        #1;
        chk("rf.v", {4'b0, fd_valid, de_valid, em_valid, mw_valid}, 8'h00);
        chk("rf.fl", {7'b0, flushing}, 8'h00);
        chk("rf.ld", {3'b0, pc_ld, fd_ld, de_ld, em_ld, mw_ld}, 8'h00);
        chk_cnt("rf.cnt_f", flush_cnt, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
